// File: rtl/rgb_host_ctrl_if.sv
// Host link and LED status bundle for rgb_host_ctrl.
// master drives the host pins; slave is the controller.
interface rgb_host_ctrl_if;
  logic       host_sel;
  logic       host_dat;
  logic       host_stb;
  logic [2:0] rgb;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  modport master (
    output host_sel, host_dat, host_stb,
    input  rgb, frame_ok, frame_err, busy
  );

  modport slave (
    input  host_sel, host_dat, host_stb,
    output rgb, frame_ok, frame_err, busy
  );
endinterface

// File: rtl/rgb_host_ctrl.sv
// rgb_host_ctrl: 3-wire framed host receiver and
// glitch-free 8-bit PWM driver for the RGB LED.
module rgb_host_ctrl #(
  parameter int unsigned PRESCALE   = 64,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  rgb_host_ctrl_if.slave bus
);
  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] CMD_DUTY = 2'b00;
  localparam logic [1:0] CMD_MODE = 2'b01;
  localparam logic [1:0] CMD_CLR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  logic [1:0] sel_q;
  logic [1:0] dat_q;
  logic [1:0] stb_q;
  logic       sel_s;
  logic       dat_s;
  logic       stb_s;
  logic       stb_d;
  logic       stb_rise;

  state_t      state;
  state_t      state_nx;
  logic [15:0] shreg;
  logic [15:0] shreg_nx;
  logic [4:0]  cnt;
  logic [4:0]  cnt_nx;
  logic        ok_nx;
  logic        err_nx;
  logic        ok_q;
  logic        err_q;

  logic [1:0]      cmd;
  logic [1:0]      chan;
  logic [7:0]      val;
  logic            rsvd_unused;
  logic            commit;
  logic [2:0][7:0] shadow;
  logic [2:0][7:0] shadow_nx;
  logic [2:0][7:0] active;
  logic            pass;
  logic            pass_nx;

  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    pwm_cnt;
  logic [2:0]    on;
  logic [2:0]    rgb_nx;
  logic [2:0]    rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      dat_q <= '0;
      stb_q <= '0;
      stb_d <= 1'b0;
    end else begin
      sel_q <= {sel_q[0], bus.host_sel};
      dat_q <= {dat_q[0], bus.host_dat};
      stb_q <= {stb_q[0], bus.host_stb};
      stb_d <= stb_s;
    end
  end

  assign sel_s    = sel_q[1];
  assign dat_s    = dat_q[1];
  assign stb_s    = stb_q[1];
  assign stb_rise = stb_s & ~stb_d;

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    ok_nx    = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_s) begin
          state_nx = SHIFT;
          shreg_nx = '0;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        if (!sel_s) begin
          if (cnt == 5'd16) begin
            state_nx = COMMIT;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end else if (stb_rise) begin
          shreg_nx = {shreg[14:0], dat_s};
          if (cnt != 5'd17) cnt_nx = cnt + 5'd1;
        end
      end
      COMMIT: begin
        ok_nx    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd         = shreg[15:14];
  assign chan        = shreg[13:12];
  assign val         = shreg[7:0];
  assign rsvd_unused = ^shreg[11:8];
  assign commit      = (state == COMMIT);

  // Shadow index follows rgb bit order, so chan 0 (red) is index 2.
  always_comb begin
    shadow_nx = shadow;
    pass_nx   = pass;
    if (commit) begin
      unique case (1'b1)
        cmd == CMD_DUTY: begin
          for (int i = 0; i < 3; i++) begin
            if (chan == 2'd3 || chan == 2'(2 - i))
              shadow_nx[i] = val;
          end
        end
        cmd == CMD_MODE: pass_nx = val[0];
        cmd == CMD_CLR:  shadow_nx = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      shadow <= '0;
      pass   <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      cnt    <= cnt_nx;
      ok_q   <= ok_nx;
      err_q  <= err_nx;
      shadow <= shadow_nx;
      pass   <= pass_nx;
    end
  end

  assign tick = (presc == PW'(PRESCALE - 1));

  // Active duties only move at the period wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
      active  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
        if (pwm_cnt == 8'hFF) active <= shadow;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      on[i] = (pwm_cnt < active[i]);
    end
  end

  assign rgb_nx = pass ? {sel_s, dat_s, stb_s}
                       : (on ^ {3{ACTIVE_LOW}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= {3{ACTIVE_LOW}};
    else        rgb_q <= rgb_nx;
  end

  assign bus.rgb       = rgb_q;
  assign bus.frame_ok  = ok_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state == SHIFT);
endmodule

// File: tb/tb_rgb_host_ctrl.sv
// Bench for rgb_host_ctrl: vector table, random frames
// against a duty model, plus passthrough/reset sequences.
module tb_rgb_host_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  rgb_host_ctrl_if bus ();

  rgb_host_ctrl #(
    .PRESCALE  (1),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int ok_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int ok_lat;
  int busy_lat;
  int on_cnt [3];
  int duty   [3];

  typedef struct {
    logic [16:0] bits;
    int          n;
    int          ok;
    int          err;
    int          r;
    int          g;
    int          b;
  } vec_t;

  vec_t vecs [8];

  always @(negedge clk) begin
    if (bus.frame_ok)  ok_cnt++;
    if (bus.frame_err) err_cnt++;
    if (bus.frame_ok && bus.frame_err) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [16:0] bits,
                            input int n);
    bus.host_sel = 1'b1;
    busy_lat = -1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (busy_lat < 0 && bus.busy) busy_lat = k;
    end
    for (int i = n - 1; i >= 0; i--) begin
      bus.host_dat = bits[i];
      step(4);
      bus.host_stb = 1'b1;
      step(4);
      bus.host_stb = 1'b0;
    end
    step(4);
    bus.host_sel = 1'b0;
    bus.host_dat = 1'b0;
    ok_lat = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (ok_lat < 0 && bus.frame_ok) ok_lat = k;
    end
  endtask

  task automatic measure();
    step(260);
    for (int i = 0; i < 3; i++) on_cnt[i] = 0;
    repeat (256) begin
      step();
      for (int i = 0; i < 3; i++) begin
        if (bus.rgb[i] == 1'b0) on_cnt[i]++;
      end
    end
  endtask

  task automatic check_duties(input string tag);
    measure();
    check({tag, "_r"}, on_cnt[2], duty[2]);
    check({tag, "_g"}, on_cnt[1], duty[1]);
    check({tag, "_b"}, on_cnt[0], duty[0]);
  endtask

  initial begin
    int ok0, err0, bad_rgb, bad_pulse, bad_busy;
    logic [1:0]  cmd, chan;
    logic [7:0]  val;
    logic [3:0]  rsv;
    logic [16:0] frame;
    logic [2:0]  pat [6];
    logic [2:0]  prev;
    int          n;

    vecs[0] = '{17'h00080, 16, 1, 0, 'h80, 0, 0};
    vecs[1] = '{17'h030FF, 16, 1, 0, 'hFF, 'hFF, 'hFF};
    vecs[2] = '{17'h0C000, 16, 1, 0, 0, 0, 0};
    vecs[3] = '{17'h01A33, 16, 1, 0, 0, 'h33, 0};
    vecs[4] = '{17'h02011, 15, 0, 1, 0, 'h33, 0};
    vecs[5] = '{17'h00077, 17, 0, 1, 0, 'h33, 0};
    vecs[6] = '{17'h08000, 16, 1, 0, 0, 'h33, 0};
    vecs[7] = '{17'h02010, 16, 1, 0, 0, 'h33, 'h10};

    rst_n        = 1'b0;
    bus.host_sel = 1'b0;
    bus.host_dat = 1'b0;
    bus.host_stb = 1'b0;

    bad_rgb = 0; bad_pulse = 0; bad_busy = 0;
    for (int k = 0; k < 24; k++) begin
      {bus.host_sel, bus.host_dat, bus.host_stb} =
        3'($urandom_range(0, 7));
      step();
      if (bus.rgb !== 3'b111) bad_rgb++;
      if (bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0)
        bad_pulse++;
      if (bus.busy !== 1'b0) bad_busy++;
    end
    check("reset_rgb", bad_rgb, 0);
    check("reset_pulse", bad_pulse, 0);
    check("reset_busy", bad_busy, 0);
    bus.host_sel = 1'b0;
    bus.host_dat = 1'b0;
    bus.host_stb = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(5);

    foreach (vecs[i]) begin
      ok0 = ok_cnt;
      err0 = err_cnt;
      send_frame(vecs[i].bits, vecs[i].n);
      check($sformatf("vec%0d_ok", i), ok_cnt - ok0, vecs[i].ok);
      check($sformatf("vec%0d_err", i), err_cnt - err0, vecs[i].err);
      if (vecs[i].n == 16) begin
        check($sformatf("vec%0d_ok_lat", i), ok_lat, 4);
        check($sformatf("vec%0d_busy_lat", i), busy_lat, 3);
      end
      duty[2] = vecs[i].r;
      duty[1] = vecs[i].g;
      duty[0] = vecs[i].b;
      check_duties($sformatf("vec%0d", i));
    end

    for (int t = 0; t < 12; t++) begin
      cmd  = 2'($urandom_range(0, 3));
      chan = 2'($urandom_range(0, 3));
      val  = 8'($urandom_range(0, 255));
      rsv  = 4'($urandom_range(0, 15));
      if (cmd == 2'b01) val[0] = 1'b0;
      n = 16;
      if ($urandom_range(0, 4) == 0)
        n = ($urandom_range(0, 1) == 1) ? 17 : 15;
      frame = {1'($urandom_range(0, 1)), cmd, chan, rsv, val};
      if (n == 16) begin
        case (cmd)
          2'b00:
            for (int i = 0; i < 3; i++)
              if (chan == 2'd3 || int'(chan) == 2 - i)
                duty[i] = int'(val);
          2'b11:
            for (int i = 0; i < 3; i++) duty[i] = 0;
          default: ;
        endcase
      end
      ok0 = ok_cnt;
      err0 = err_cnt;
      send_frame(frame, n);
      check($sformatf("rnd%0d_ok", t), ok_cnt - ok0,
            (n == 16) ? 1 : 0);
      check($sformatf("rnd%0d_err", t), err_cnt - err0,
            (n == 16) ? 0 : 1);
      check_duties($sformatf("rnd%0d", t));
    end

    ok0 = ok_cnt;
    send_frame(17'h04001, 16);
    check("pt_on_ok", ok_cnt - ok0, 1);
    check("pt_idle_rgb", bus.rgb, 3'b000);
    pat[0] = 3'b010; pat[1] = 3'b011; pat[2] = 3'b001;
    pat[3] = 3'b000; pat[4] = 3'b100; pat[5] = 3'b000;
    prev = 3'b000;
    foreach (pat[i]) begin
      {bus.host_sel, bus.host_dat, bus.host_stb} = pat[i];
      step(2);
      check($sformatf("pt%0d_early", i), bus.rgb, prev);
      step(1);
      check($sformatf("pt%0d_lat3", i), bus.rgb, pat[i]);
      step(2);
      prev = pat[i];
    end
    step(6);
    ok0 = ok_cnt;
    send_frame(17'h04000, 16);
    check("pt_off_ok", ok_cnt - ok0, 1);
    check_duties("pt_off");

    ok0 = ok_cnt;
    err0 = err_cnt;
    bus.host_sel = 1'b1;
    step(4);
    for (int i = 0; i < 8; i++) begin
      bus.host_dat = 1'(i % 2);
      step(4);
      bus.host_stb = 1'b1;
      step(4);
      bus.host_stb = 1'b0;
    end
    step(2);
    rst_n = 1'b0;
    step(1);
    check("rst_mid_busy", bus.busy, 1'b0);
    bus.host_sel = 1'b0;
    bus.host_dat = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(6);
    check("rst_mid_ok", ok_cnt - ok0, 0);
    check("rst_mid_err", err_cnt - err0, 0);
    for (int i = 0; i < 3; i++) duty[i] = 0;
    check_duties("rst_mid");
    ok0 = ok_cnt;
    send_frame(17'h01040, 16);
    check("rst_after_ok", ok_cnt - ok0, 1);
    duty[1] = 'h40;
    check_duties("rst_after");

    check("ok_err_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rgb_host_ctrl.md
# rgb_host_ctrl

Host-link command receiver and PWM scheduler for the on-board RGB LED. It takes the three RP2040 host lines (pico17/18/19) as a 3-wire framed serial link and decodes 16-bit command frames. It holds per-channel 8-bit duty registers and drives the three LED pins with glitch-free PWM. A passthrough mode keeps the legacy "pins drive LED directly" behaviour available under host control.

## Interface
- `PRESCALE`, 64: clk cycles per PWM tick (≥1); 8-bit PWM period = 256·PRESCALE clk.
- `ACTIVE_LOW`, 1: LED pin polarity; 1 ⇒ pin driven 0 means LED on.
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `host_sel` in 1: pico17, frame select, active-high, asynchronous to clk.
- `host_dat` in 1: pico18, serial data, MSB first, asynchronous.
- `host_stb` in 1: pico19, bit strobe; data sampled on its rising edge, asynchronous.
- `rgb` out 3: LED pins; [2]=red, [1]=green, [0]=blue.
- `frame_ok` out 1: one-clk pulse, valid frame committed.
- `frame_err` out 1: one-clk pulse, frame discarded.
- `busy` out 1: high while a frame is being received (FSM in SHIFT).

## Operation
- Each host input passes through a 2-FF synchronizer (sel_s, dat_s, stb_s), then a 1-FF edge detector.
- Frame format, 16 bits, MSB first:
  - [15:14] cmd
  - [13:12] chan: 0=R, 1=G, 2=B, 3=all
  - [11:8] reserved, ignored
  - [7:0] value
- Commands:
  - 00 SET_DUTY: shadow duty[chan] ← value.
  - 01 SET_MODE: passthrough ← value[0].
  - 10 NOP: frame_ok only.
  - 11 CLEAR: all shadow duties ← 0 (chan ignored).
- FSM, three states:
  - IDLE: sel_s=1 ⇒ SHIFT; clear shift register and bit count.
  - SHIFT, while sel_s=1: on each stb_s rising edge, shift dat_s in and increment bit count; count saturates at 17.
  - SHIFT, when sel_s=0: count==16 ⇒ COMMIT; otherwise pulse frame_err and go to IDLE.
  - COMMIT: apply the command, pulse frame_ok, go to IDLE (1 cycle).
- An stb_s edge in the same cycle that sel_s is 0 is discarded.
- Frames are decoded in both modes, so the host can always leave passthrough.
- PWM:
  - The prescaler issues a tick every PRESCALE clk.
  - An 8-bit pwm_cnt increments on each tick and wraps 255→0.
  - Channel on ⇔ pwm_cnt < active_duty.
  - Active duties load from shadow only on the tick where pwm_cnt wraps to 0, so there are no mid-period glitches.
  - Duty 0 ⇒ always off; 255 ⇒ on 255/256 of the period.
- Output stage:
  - Normal mode: rgb[i] = on_i XOR ACTIVE_LOW, registered.
  - Passthrough: rgb = {sel_s, dat_s, stb_s}, registered, no polarity inversion.
- rgb is always a registered output.

## Timing
- Reset values:
  - rgb = {3{ACTIVE_LOW}}; frame_ok=0, frame_err=0, busy=0.
  - Shadow and active duties = 0; passthrough=0; pwm_cnt=0; prescaler=0; FSM=IDLE; synchronizers=0.
- Reset mid-frame aborts the frame with no pulse and no register change. The first frame after rst_n deasserts is accepted normally.
- Latency from a host_sel falling edge captured by clk to frame_ok/frame_err: 3 clk synchronizer+edge, +1 clk for COMMIT.
  - frame_ok and frame_err are each exactly 1 clk wide and are never asserted together.
- Commit to LED effect: shadow updates in the COMMIT cycle; the LED changes at the next pwm_cnt wrap, at most 256·PRESCALE clk later.
- Passthrough entry/exit takes effect the clk after COMMIT. Pin-to-rgb latency in passthrough is 3 clk.
- Host rules:
  - Each stb high and low phase ≥ 3 clk.
  - dat stable 3 clk before a stb rise.
  - sel falls ≥ 3 clk after the last stb rise.
  - Inter-frame sel low ≥ 3 clk.
  - Violations may lose bits; the bit-count check then yields frame_err.
- busy rises 3 clk after a sel rising edge and falls on exit from SHIFT.

## Test plan
- Reset: hold rst_n=0, toggle host pins → rgb=3'b111, frame_ok=frame_err=busy=0 throughout.
- SET_DUTY R=0x80 (frame 0x0080), PRESCALE=1:
  - frame_ok one pulse, 4 clk after sel falls.
  - After the next wrap, rgb[2]=0 for 128 and 1 for 128 of every 256 clk.
  - G and B stay 1.
- SET_DUTY chan=3 value 0xFF (0x30FF):
  - All channels on 255/256 from the next wrap.
  - Then CLEAR (0xC000) → all rgb=1 from the following wrap.
- Bad frames:
  - 15-bit frame → frame_err, no frame_ok, duties unchanged.
  - 17-bit frame → frame_err.
  - Next valid frame → frame_ok.
- SET_MODE 1 (0x4001):
  - rgb follows {host_sel, host_dat, host_stb} with 3-clk latency, non-inverted.
  - SET_MODE 0 sent while in passthrough restores PWM output.
- Reset mid-frame: assert rst_n=0 after 8 strobes of a SET_DUTY frame → no pulse, duties 0, busy=0; a complete frame after release gives frame_ok.
